hazard_detection_unit: RTL and testbench
========================================

// Module: hazard_detection_unit
// PURPOSE
//  Stall/flush controller for the 5-stage pipeline; covers what EX-stage bypassing cannot.
//  Inspects the IF/ID instruction against producers in ID/EX and EX/MEM.
//  Drives PC/IF_ID write enables and bubble/flush strobes.
//  Sequences HLT drain, flags runaway stalls.
//  Sits in ID, beside the register file and branch resolution.
// PARAMETERS
//  DRAIN_CYCLES  3   bubble cycles after HLT in ID before halted asserts (pipeline empty)
//  MAX_STALL     7   consecutive stall cycles that set stall_err
//  STAT_W        16  width of statistics counters (HAZARD_STATS_EN only)
// PORTS
//  clk              in   1  clock, rising edge
//  rst              in   1  asynchronous reset, active-high
//  IF_ID_Rs         in   4  source reg 1 of instruction in ID
//  IF_ID_Rt         in   4  source reg 2 of instruction in ID
//  IF_ID_usesRs     in   1  ID instruction reads Rs
//  IF_ID_usesRt     in   1  ID instruction reads Rt
//  IF_ID_isBR       in   1  ID holds BR; target in Rs, read in ID, no bypass to ID
//  IF_ID_isB        in   1  ID holds B; condition uses flags
//  IF_ID_isHLT      in   1  ID holds HLT
//  branch_taken     in   1  branch in ID resolved taken (valid only when not stalled)
//  ID_EX_Rd         in   4  EX-stage destination
//  ID_EX_RegWrite   in   1  EX-stage writes Rd
//  ID_EX_MemRead    in   1  EX-stage is LW
//  ID_EX_setsFlags  in   1  EX-stage updates Z/V/N
//  EX_MEM_Rd        in   4  MEM-stage destination
//  EX_MEM_RegWrite  in   1  MEM-stage writes Rd
//  PC_write         out  1  1 = PC may update
//  IF_ID_write      out  1  1 = IF/ID may load
//  IF_ID_flush      out  1  1 = IF/ID loads NOP next edge
//  ID_EX_flush      out  1  1 = ID/EX loads bubble (controls 0) next edge
//  halted           out  1  sticky: pipeline drained after HLT
//  stall_err        out  1  sticky: stall run reached MAX_STALL
// BEHAVIOUR
//  Reg 0 never creates a hazard; any compare with Rs/Rt == 0 is false.
//  Hazard terms, combinational:
//   loaduse = ID_EX_MemRead & ID_EX_Rd match (usesRs&Rs | usesRt&Rt).
//   brdep   = IF_ID_isBR & ((ID_EX_RegWrite & ID_EX_Rd==Rs) | (EX_MEM_RegWrite & EX_MEM_Rd==Rs)).
//   flagdep = IF_ID_isB & ID_EX_setsFlags.
//   stall   = loaduse | brdep | flagdep.
//  FSM states RUN, DRAIN, HALTED; registered, reset -> RUN.
//  RUN:
//   stall -> PC_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0.
//   else branch_taken -> IF_ID_flush=1, others 1/0, i.e. 1-cycle penalty.
//   else IF_ID_isHLT -> PC_write=0, IF_ID_write=0, ID_EX_flush=0 (HLT enters EX).
//     Then drain_cnt <= DRAIN_CYCLES-1; go to DRAIN.
//   else PC_write=1, IF_ID_write=1, flushes 0.
//  DRAIN: PC_write=0, IF_ID_write=0, ID_EX_flush=1.
//   drain_cnt decrements each cycle; at 0 -> HALTED next edge.
//  HALTED: halted=1, PC_write=0, IF_ID_write=0, ID_EX_flush=1. Stays until rst.
//  branch_taken is ignored while stall=1; the branch re-evaluates once unstalled.
//  stall_run counter (3b min, sized for MAX_STALL):
//   +1 on each RUN-state stall cycle, clears on a non-stall cycle, saturates.
//   stall_err sets when stall_run reaches MAX_STALL.
//  Control outputs are combinational from state + inputs, zero latency.
//   halted and stall_err are registered.
//  Reset, any time incl. mid-DRAIN: state=RUN, counters=0, halted=0, stall_err=0.
//   With all inputs 0 the outputs are PC_write=1, IF_ID_write=1, flushes=0.
// CONFIGURATION
//  HAZARD_STATS_EN defined adds outputs stall_cycles[STAT_W], flush_count[STAT_W].
//   stall_cycles: +1 per RUN stall cycle. flush_count: +1 per IF_ID_flush cycle.
//   Both saturate at all-ones and reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  LW r3 in EX, ID uses Rs=3 -> 1 cycle PC_write=0, IF_ID_write=0, ID_EX_flush=1; then RUN.
//  BR r5, ADD r5 in EX -> stall; next cycle r5 in MEM -> stall; cycle 3 -> no stall (2 stalls total).
//  Same BR with Rd=0 producer, or LW r0 load-use -> no stall.
//  B after flag-setting ADD in EX -> 1 stall.
//   Then branch_taken=1 -> IF_ID_flush=1 for exactly 1 cycle.
//  HLT in ID -> PC_write=0 immediately, 3 DRAIN cycles, halted=1 on 4th edge.
//   Held through 10 idle cycles; rst mid-DRAIN -> halted stays 0, state RUN.
//  Hold loaduse true 7 cycles -> stall_err=1 on 7th edge, sticky.
//   With HAZARD_STATS_EN -> stall_cycles=7.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// ============================================================================
// hazard_detection_unit
// ----------------------------------------------------------------------------
// Stall/flush controller for the 5-stage pipeline. It sits in ID, next to the
// register file and branch resolution, and handles the hazards that EX-stage
// bypassing cannot: load-use, BR target reads in ID, and B reading flags that
// are still being produced in EX. It also sequences the HLT drain and flags
// stall runs that last too long.
//
// Optional feature macro: HAZARD_STATS_EN
//   When defined, adds the stall_cycles / flush_count statistics outputs.
//   When undefined, those ports and counters do not exist.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   IF_ID_*            decoded fields of the instruction in ID
//   branch_taken       branch in ID resolved taken (meaningful only unstalled)
//   ID_EX_*            producer in EX (dest, RegWrite, MemRead, setsFlags)
//   EX_MEM_*           producer in MEM (dest, RegWrite)
//   PC_write           1 = PC may update
//   IF_ID_write        1 = IF/ID may load
//   IF_ID_flush        1 = IF/ID loads a NOP on the next edge
//   ID_EX_flush        1 = ID/EX loads a bubble on the next edge
//   halted             sticky, registered: pipeline drained after HLT
//   stall_err          sticky, registered: stall run reached MAX_STALL
//   dbg_state          current FSM state (0 = RUN, 1 = DRAIN, 2 = HALTED)
//   stall_cycles       (HAZARD_STATS_EN) saturating count of RUN stall cycles
//   flush_count        (HAZARD_STATS_EN) saturating count of IF_ID_flush cycles
//
// Control outputs are combinational from state + inputs (zero latency).
// Handshake note: there is no valid/ready pair here; PC_write/IF_ID_write act
// as the "ready" of the front end and are sampled by the pipeline registers
// on the same rising edge they are presented.
// ============================================================================
module hazard_detection_unit #(
    parameter int DRAIN_CYCLES = 3,   // must be >= 1
    parameter int MAX_STALL    = 7,
    parameter int STAT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       IF_ID_Rs,
    input  logic [3:0]       IF_ID_Rt,
    input  logic             IF_ID_usesRs,
    input  logic             IF_ID_usesRt,
    input  logic             IF_ID_isBR,
    input  logic             IF_ID_isB,
    input  logic             IF_ID_isHLT,
    input  logic             branch_taken,
    input  logic [3:0]       ID_EX_Rd,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_setsFlags,
    input  logic [3:0]       EX_MEM_Rd,
    input  logic             EX_MEM_RegWrite,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             halted,
    output logic             stall_err,
    output logic [1:0]       dbg_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count
`endif
);

    // Stall-run counter is at least 3 bits and wide enough to hold MAX_STALL.
    localparam int RUN_W_RAW = $clog2(MAX_STALL + 1);
    localparam int RUN_W     = (RUN_W_RAW < 3) ? 3 : RUN_W_RAW;
    localparam int DRAIN_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             r_state;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [RUN_W-1:0]   r_stall_run;
    logic               r_halted;
    logic               r_stall_err;

    logic w_rs_nz;
    logic w_rt_nz;
    logic w_loaduse;
    logic w_brdep;
    logic w_flagdep;
    logic w_stall;
    logic w_run_stall;

    // Register 0 is hard-wired zero, so a source of r0 never depends on anyone.
    assign w_rs_nz = |IF_ID_Rs;
    assign w_rt_nz = |IF_ID_Rt;

    assign w_loaduse = ID_EX_MemRead &
                       ((IF_ID_usesRs & w_rs_nz & (ID_EX_Rd == IF_ID_Rs)) |
                        (IF_ID_usesRt & w_rt_nz & (ID_EX_Rd == IF_ID_Rt)));

    // BR reads its target in ID where no bypass exists, so any in-flight
    // writer of Rs (EX or MEM) must retire first.
    assign w_brdep = IF_ID_isBR & w_rs_nz &
                     ((ID_EX_RegWrite  & (ID_EX_Rd  == IF_ID_Rs)) |
                      (EX_MEM_RegWrite & (EX_MEM_Rd == IF_ID_Rs)));

    assign w_flagdep = IF_ID_isB & ID_EX_setsFlags;

    assign w_stall     = w_loaduse | w_brdep | w_flagdep;
    assign w_run_stall = (r_state == ST_RUN) & w_stall;

    // Control outputs. Priority in RUN: stall > taken branch > HLT, so a
    // taken branch seen during a stall is dropped and re-evaluated later.
    always_comb begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_stall) begin
                    PC_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    ID_EX_flush = 1'b1;
                end else if (branch_taken) begin
                    IF_ID_flush = 1'b1;
                end else if (IF_ID_isHLT) begin
                    // HLT itself proceeds into EX; only the front end freezes.
                    PC_write    = 1'b0;
                    IF_ID_write = 1'b0;
                end
            end
            default: begin
                // DRAIN and HALTED: front end frozen, bubbles fed behind HLT.
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                ID_EX_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_stall_run <= '0;
            r_halted    <= 1'b0;
            r_stall_err <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!w_stall && !branch_taken && IF_ID_isHLT) begin
                        r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase

            // Only RUN-state stalls extend a run; anything else ends it.
            if (w_run_stall) begin
                if (r_stall_run != RUN_W'(MAX_STALL)) begin
                    r_stall_run <= r_stall_run + RUN_W'(1);
                end
                if (r_stall_run == RUN_W'(MAX_STALL - 1)) begin
                    r_stall_err <= 1'b1;
                end
            end else begin
                r_stall_run <= '0;
            end
        end
    end

    assign halted    = r_halted;
    assign stall_err = r_stall_err;
    assign dbg_state = r_state;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] r_stall_cycles;
    logic [STAT_W-1:0] r_flush_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_run_stall && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + STAT_W'(1);
            end
            if (IF_ID_flush && !(&r_flush_count)) begin
                r_flush_count <= r_flush_count + STAT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Testbench for hazard_detection_unit.
// Expected output vector layout: {PC_write, IF_ID_write, IF_ID_flush,
// ID_EX_flush, halted, stall_err}. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_hazard_detection_unit;

    localparam int STAT_W = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Rd, EX_MEM_Rd;
    logic       IF_ID_usesRs, IF_ID_usesRt, IF_ID_isBR, IF_ID_isB, IF_ID_isHLT;
    logic       branch_taken, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_setsFlags;
    logic       EX_MEM_RegWrite;
    logic       PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, halted, stall_err;
    logic [1:0] dbg_state;
`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cycles, flush_count;
`endif

    hazard_detection_unit #(
        .DRAIN_CYCLES(3),
        .MAX_STALL(7),
        .STAT_W(STAT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .IF_ID_Rs(IF_ID_Rs),
        .IF_ID_Rt(IF_ID_Rt),
        .IF_ID_usesRs(IF_ID_usesRs),
        .IF_ID_usesRt(IF_ID_usesRt),
        .IF_ID_isBR(IF_ID_isBR),
        .IF_ID_isB(IF_ID_isB),
        .IF_ID_isHLT(IF_ID_isHLT),
        .branch_taken(branch_taken),
        .ID_EX_Rd(ID_EX_Rd),
        .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_setsFlags(ID_EX_setsFlags),
        .EX_MEM_Rd(EX_MEM_Rd),
        .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .PC_write(PC_write),
        .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush),
        .halted(halted),
        .stall_err(stall_err),
        .dbg_state(dbg_state)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
`endif
    );

    typedef struct packed {
        logic [3:0] rs;
        logic [3:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       is_br;
        logic       is_b;
        logic       is_hlt;
        logic       br_taken;
        logic [3:0] idex_rd;
        logic       idex_rw;
        logic       idex_mr;
        logic       idex_sf;
        logic [3:0] exmem_rd;
        logic       exmem_rw;
    } stim_t;

    localparam logic [5:0] E_RUN    = 6'b110000;
    localparam logic [5:0] E_STALL  = 6'b000100;
    localparam logic [5:0] E_FLUSH  = 6'b111000;
    localparam logic [5:0] E_HLT    = 6'b000000;
    localparam logic [5:0] E_DRAIN  = 6'b000100;
    localparam logic [5:0] E_HALTED = 6'b000110;
    localparam logic [5:0] E_ERR    = 6'b000001;

    logic [5:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic apply(input stim_t s);
        IF_ID_Rs        = s.rs;
        IF_ID_Rt        = s.rt;
        IF_ID_usesRs    = s.uses_rs;
        IF_ID_usesRt    = s.uses_rt;
        IF_ID_isBR      = s.is_br;
        IF_ID_isB       = s.is_b;
        IF_ID_isHLT     = s.is_hlt;
        branch_taken    = s.br_taken;
        ID_EX_Rd        = s.idex_rd;
        ID_EX_RegWrite  = s.idex_rw;
        ID_EX_MemRead   = s.idex_mr;
        ID_EX_setsFlags = s.idex_sf;
        EX_MEM_Rd       = s.exmem_rd;
        EX_MEM_RegWrite = s.exmem_rw;
    endtask

    // Drive one cycle of stimulus, record what the outputs must be, and move
    // to the sampling point (falling edge).
    task automatic drive(input stim_t s, input logic [5:0] e);
        apply(s);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge with rst released.
    task automatic do_reset();
        apply('0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [5:0] obs_vec();
        return {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, halted, stall_err};
    endfunction

    function automatic stim_t lw_use(input logic [3:0] rd, input logic [3:0] rs);
        stim_t s;
        s = '0;
        s.idex_mr = 1'b1;
        s.idex_rw = 1'b1;
        s.idex_rd = rd;
        s.uses_rs = 1'b1;
        s.rs      = rs;
        return s;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [5:0] got, expv;
        apply('0);
        rst = 1'b1;
        exp_q.push_back(E_RUN);
        @(negedge clk);
        got = obs_vec(); expv = exp_q.pop_front(); n_cmp++;
        if (got !== expv) begin
            n_mis++; $display("FAIL reset_outputs: got %b expected %b", got, expv);
        end
        n_cmp++;
        if (dbg_state !== 2'd0) begin
            n_mis++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive('0, E_RUN);
        got = obs_vec(); expv = exp_q.pop_front(); n_cmp++;
        if (got !== expv) begin
            n_mis++; $display("FAIL reset_idle: got %b expected %b", got, expv);
        end
`ifdef HAZARD_STATS_EN
        n_cmp++;
        if (stall_cycles !== '0 || flush_count !== '0) begin
            n_mis++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        end
`endif
        advance();
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [5:0] ex[$];
        stim_t s;
        logic [5:0] got, expv;
        do_reset();
        st.push_back(lw_use(4'd3, 4'd3));             ex.push_back(E_STALL);
        s = '0; s.exmem_rd = 4'd3; s.exmem_rw = 1'b1;
        s.uses_rs = 1'b1; s.rs = 4'd3;
        st.push_back(s);                              ex.push_back(E_RUN);
        s = lw_use(4'd7, 4'd1); s.uses_rt = 1'b1; s.rt = 4'd7;
        st.push_back(s);                              ex.push_back(E_STALL);
        s = lw_use(4'd7, 4'd1); s.rt = 4'd7;          // Rt matches but unused
        st.push_back(s);                              ex.push_back(E_RUN);
        st.push_back(lw_use(4'd0, 4'd0));             ex.push_back(E_RUN);
        s = lw_use(4'd3, 4'd3); s.idex_mr = 1'b0;     // ALU producer: bypassed
        st.push_back(s);                              ex.push_back(E_RUN);
        st.push_back(lw_use(4'd3, 4'd4));             ex.push_back(E_RUN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            got = obs_vec(); expv = exp_q.pop_front(); n_cmp++;
            if (got !== expv) begin
                n_mis++; $display("FAIL load_use[%0d]: got %b expected %b", i, got, expv);
            end
            advance();
        end
    endtask

    task automatic test_branch_reg();
        stim_t st[$];
        logic [5:0] ex[$];
        stim_t s, br;
        logic [5:0] got, expv;
        do_reset();
        br = '0; br.is_br = 1'b1; br.uses_rs = 1'b1; br.rs = 4'd5; br.br_taken = 1'b1;
        s = br; s.idex_rd = 4'd5; s.idex_rw = 1'b1;
        st.push_back(s);                   ex.push_back(E_STALL);
        s = br; s.exmem_rd = 4'd5; s.exmem_rw = 1'b1;
        st.push_back(s);                   ex.push_back(E_STALL);
        st.push_back(br);                  ex.push_back(E_FLUSH);
        st.push_back('0);                  ex.push_back(E_RUN);
        s = br; s.br_taken = 1'b0; s.idex_rd = 4'd0; s.idex_rw = 1'b1;
        st.push_back(s);                   ex.push_back(E_RUN);
        s = br; s.br_taken = 1'b0; s.rs = 4'd0; s.idex_rw = 1'b1; s.exmem_rw = 1'b1;
        st.push_back(s);                   ex.push_back(E_RUN);
        s = br; s.br_taken = 1'b0; s.idex_rd = 4'd5; s.exmem_rd = 4'd6; s.exmem_rw = 1'b1;
        st.push_back(s);                   ex.push_back(E_RUN);
        s = br; s.br_taken = 1'b0; s.is_br = 1'b0; s.idex_rd = 4'd5; s.idex_rw = 1'b1;
        st.push_back(s);                   ex.push_back(E_RUN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            got = obs_vec(); expv = exp_q.pop_front(); n_cmp++;
            if (got !== expv) begin
                n_mis++; $display("FAIL branch_reg[%0d]: got %b expected %b", i, got, expv);
            end
            advance();
        end
    endtask

    task automatic test_flag_branch();
        stim_t st[$];
        logic [5:0] ex[$];
        stim_t s;
        logic [5:0] got, expv;
        do_reset();
        s = '0; s.is_b = 1'b1; s.idex_sf = 1'b1; s.br_taken = 1'b1;
        st.push_back(s);                   ex.push_back(E_STALL);
        s = '0; s.is_b = 1'b1; s.br_taken = 1'b1;
        st.push_back(s);                   ex.push_back(E_FLUSH);
        st.push_back('0);                  ex.push_back(E_RUN);
        s = '0; s.idex_sf = 1'b1;
        st.push_back(s);                   ex.push_back(E_RUN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            got = obs_vec(); expv = exp_q.pop_front(); n_cmp++;
            if (got !== expv) begin
                n_mis++; $display("FAIL flag_branch[%0d]: got %b expected %b", i, got, expv);
            end
            advance();
        end
`ifdef HAZARD_STATS_EN
        n_cmp++;
        if (stall_cycles !== STAT_W'(1) || flush_count !== STAT_W'(1)) begin
            n_mis++; $display("FAIL flag_stats: got %0d/%0d expected 1/1", stall_cycles, flush_count);
        end
`endif
    endtask

    // Two 6-cycle runs separated by a free cycle must not trip stall_err.
    task automatic test_stall_below();
        stim_t st[$];
        logic [5:0] ex[$];
        logic [5:0] got, expv;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 6; k++) begin
                st.push_back(lw_use(4'd9, 4'd9)); ex.push_back(E_STALL);
            end
            st.push_back('0); ex.push_back(E_RUN);
        end
        st.push_back('0); ex.push_back(E_RUN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            got = obs_vec(); expv = exp_q.pop_front(); n_cmp++;
            if (got !== expv) begin
                n_mis++; $display("FAIL stall_below[%0d]: got %b expected %b", i, got, expv);
            end
            advance();
        end
    endtask

    task automatic test_stall_err();
        stim_t st[$];
        logic [5:0] ex[$];
        logic [5:0] got, expv;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            st.push_back(lw_use(4'd2, 4'd2)); ex.push_back(E_STALL);
        end
        st.push_back('0); ex.push_back(E_RUN | E_ERR);
        st.push_back('0); ex.push_back(E_RUN | E_ERR);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            got = obs_vec(); expv = exp_q.pop_front(); n_cmp++;
            if (got !== expv) begin
                n_mis++; $display("FAIL stall_err[%0d]: got %b expected %b", i, got, expv);
            end
            advance();
        end
`ifdef HAZARD_STATS_EN
        n_cmp++;
        if (stall_cycles !== STAT_W'(7) || flush_count !== '0) begin
            n_mis++; $display("FAIL stall_stats: got %0d/%0d expected 7/0", stall_cycles, flush_count);
        end
`endif
    endtask

    task automatic test_halt();
        stim_t st[$];
        logic [5:0] ex[$];
        stim_t s;
        logic [5:0] got, expv;
        do_reset();
        s = '0; s.is_hlt = 1'b1;
        st.push_back(s); ex.push_back(E_HLT);
        for (int k = 0; k < 3; k++) begin
            st.push_back(s); ex.push_back(E_DRAIN);
        end
        // Halted must ignore anything on the inputs, hazards and branches included.
        for (int k = 0; k < 10; k++) begin
            s = stim_t'({$urandom, $urandom});
            st.push_back(s); ex.push_back(E_HALTED);
        end
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            got = obs_vec(); expv = exp_q.pop_front(); n_cmp++;
            if (got !== expv) begin
                n_mis++; $display("FAIL halt[%0d]: got %b expected %b", i, got, expv);
            end
            advance();
        end
        n_cmp++;
        if (dbg_state !== 2'd2) begin
            n_mis++; $display("FAIL halt_state: got %0d expected 2", dbg_state);
        end
`ifdef HAZARD_STATS_EN
        n_cmp++;
        if (stall_cycles !== '0 || flush_count !== '0) begin
            n_mis++; $display("FAIL halt_stats: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        end
`endif
    endtask

    task automatic test_reset_mid_drain();
        stim_t st[$];
        logic [5:0] ex[$];
        stim_t s;
        logic [5:0] got, expv;
        do_reset();
        // HLT behind a load-use hazard: the stall wins, HLT waits.
        s = lw_use(4'd4, 4'd4); s.is_hlt = 1'b1;
        st.push_back(s); ex.push_back(E_STALL);
        s = '0; s.is_hlt = 1'b1;
        st.push_back(s); ex.push_back(E_HLT);
        st.push_back(s); ex.push_back(E_DRAIN);
        st.push_back(s); ex.push_back(E_DRAIN);
        foreach (st[i]) begin
            drive(st[i], ex[i]);
            got = obs_vec(); expv = exp_q.pop_front(); n_cmp++;
            if (got !== expv) begin
                n_mis++; $display("FAIL mid_drain[%0d]: got %b expected %b", i, got, expv);
            end
            advance();
        end
        // One drain cycle left; reset now and hold it across the edge that
        // would otherwise have entered HALTED.
        apply('0);
        rst = 1'b1;
        exp_q.push_back(E_RUN);
        #2;
        got = obs_vec(); expv = exp_q.pop_front(); n_cmp++;
        if (got !== expv) begin
            n_mis++; $display("FAIL mid_drain_rst: got %b expected %b", got, expv);
        end
        n_cmp++;
        if (dbg_state !== 2'd0) begin
            n_mis++; $display("FAIL mid_drain_state: got %0d expected 0", dbg_state);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive('0, E_RUN);
            got = obs_vec(); expv = exp_q.pop_front(); n_cmp++;
            if (got !== expv) begin
                n_mis++; $display("FAIL after_rst[%0d]: got %b expected %b", k, got, expv);
            end
            advance();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1;
        apply('0);
        test_reset();
        test_load_use();
        test_branch_reg();
        test_flag_branch();
        test_stall_below();
        test_stall_err();
        test_halt();
        test_reset_mid_drain();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
